// File: rtl/axi_s_packet_dropper.sv
// Packet-granular AXI-stream dropper: one pass/drop decision per packet, taken at its first beat,
// with saturating pass/drop statistics counters.
module axi_s_packet_dropper #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dropn,
    input  logic                  stat_clear,
    input  logic [DATA_WIDTH-1:0] s_packet_axis_tdata,
    input  logic                  s_packet_axis_tvalid,
    input  logic                  s_packet_axis_tlast,
    input  logic [KEEP_WIDTH-1:0] s_packet_axis_tkeep,
    output logic                  s_packet_axis_tready,
    output logic [DATA_WIDTH-1:0] m_packet_axis_tdata,
    output logic                  m_packet_axis_tvalid,
    output logic                  m_packet_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_packet_axis_tkeep,
    input  logic                  m_packet_axis_tready,
    output logic                  drop_active,
    output logic [CNT_WIDTH-1:0]  stat_pass_pkts,
    output logic [CNT_WIDTH-1:0]  stat_drop_pkts,
    output logic [CNT_WIDTH-1:0]  stat_drop_beats,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a beat moves on a rising edge where tvalid and tready are both high; a
    // source holds tvalid and payload until accepted, and tvalid never waits on tready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] pass_pkts_q, pass_pkts_d;
    logic [CNT_WIDTH-1:0] drop_pkts_q, drop_pkts_d;
    logic [CNT_WIDTH-1:0] drop_beats_q, drop_beats_d;
    logic                 pass_inc, drop_pkt_inc, drop_beat_inc;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                      input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && (c != CNT_MAX)) return c + CNT_ONE;
        return c;
    endfunction

    // The pass/drop decision lives in the state itself, so dropn is ignored outside IDLE.
    always_comb begin
        state_d              = state_q;
        s_packet_axis_tready = 1'b0;
        m_packet_axis_tvalid = 1'b0;
        pass_inc             = 1'b0;
        drop_pkt_inc         = 1'b0;
        drop_beat_inc        = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_packet_axis_tvalid) state_d = dropn ? PASS : DROP;
            end
            PASS: begin
                m_packet_axis_tvalid = s_packet_axis_tvalid;
                s_packet_axis_tready = m_packet_axis_tready;
                if (s_packet_axis_tvalid && m_packet_axis_tready && s_packet_axis_tlast) begin
                    pass_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            DROP: begin
                s_packet_axis_tready = 1'b1;
                if (s_packet_axis_tvalid) begin
                    drop_beat_inc = 1'b1;
                    if (s_packet_axis_tlast) begin
                        drop_pkt_inc = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pass_pkts_d  = cnt_next(pass_pkts_q, pass_inc, stat_clear);
        drop_pkts_d  = cnt_next(drop_pkts_q, drop_pkt_inc, stat_clear);
        drop_beats_d = cnt_next(drop_beats_q, drop_beat_inc, stat_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pass_pkts_q  <= '0;
            drop_pkts_q  <= '0;
            drop_beats_q <= '0;
        end else begin
            state_q      <= state_d;
            pass_pkts_q  <= pass_pkts_d;
            drop_pkts_q  <= drop_pkts_d;
            drop_beats_q <= drop_beats_d;
        end
    end

    // Payload is a straight wire; the master side ignores it whenever tvalid is low.
    assign m_packet_axis_tdata = s_packet_axis_tdata;
    assign m_packet_axis_tlast = s_packet_axis_tlast;
    assign m_packet_axis_tkeep = s_packet_axis_tkeep;

    assign drop_active     = (state_q == DROP);
    assign stat_pass_pkts  = pass_pkts_q;
    assign stat_drop_pkts  = drop_pkts_q;
    assign stat_drop_beats = drop_beats_q;
    // Debug view of the state: 0 = IDLE, 1 = PASS, 2 = DROP.
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_axi_s_packet_dropper.sv
// Randomised bench for axi_s_packet_dropper: packet-level reference model, expected-beat queues
// drained by a monitor, and counter checks against saturating model counts.
module tb_axi_s_packet_dropper;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int EW = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst, dropn, stat_clear;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tlast;
    logic [KW-1:0] s_tkeep;
    logic          m_tready;

    logic          s_tready, m_tvalid, m_tlast, drop_active;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [31:0]   stat_pass, stat_dpk, stat_dbt;
    logic [1:0]    dbg_state;

    logic          s2_s_tready, s2_m_tvalid, s2_m_tlast, s2_drop_active;
    logic [DW-1:0] s2_m_tdata;
    logic [KW-1:0] s2_m_tkeep;
    logic [3:0]    s2_stat_pass, s2_stat_dpk, s2_stat_dbt;
    logic [1:0]    s2_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_pct = 100;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_q2[$];

    longint pass_c, dpk_c, dbt_c;

    always #5 clk = ~clk;

    axi_s_packet_dropper #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .dropn(dropn), .stat_clear(stat_clear),
        .s_packet_axis_tdata(s_tdata), .s_packet_axis_tvalid(s_tvalid),
        .s_packet_axis_tlast(s_tlast), .s_packet_axis_tkeep(s_tkeep),
        .s_packet_axis_tready(s_tready),
        .m_packet_axis_tdata(m_tdata), .m_packet_axis_tvalid(m_tvalid),
        .m_packet_axis_tlast(m_tlast), .m_packet_axis_tkeep(m_tkeep),
        .m_packet_axis_tready(m_tready),
        .drop_active(drop_active), .stat_pass_pkts(stat_pass),
        .stat_drop_pkts(stat_dpk), .stat_drop_beats(stat_dbt), .dbg_state_o(dbg_state)
    );

    axi_s_packet_dropper #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .dropn(dropn), .stat_clear(stat_clear),
        .s_packet_axis_tdata(s_tdata), .s_packet_axis_tvalid(s_tvalid),
        .s_packet_axis_tlast(s_tlast), .s_packet_axis_tkeep(s_tkeep),
        .s_packet_axis_tready(s2_s_tready),
        .m_packet_axis_tdata(s2_m_tdata), .m_packet_axis_tvalid(s2_m_tvalid),
        .m_packet_axis_tlast(s2_m_tlast), .m_packet_axis_tkeep(s2_m_tkeep),
        .m_packet_axis_tready(m_tready),
        .drop_active(s2_drop_active), .stat_pass_pkts(s2_stat_pass),
        .stat_drop_pkts(s2_stat_dpk), .stat_drop_beats(s2_stat_dbt), .dbg_state_o(s2_dbg_state)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint satv(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic zero_model();
        pass_c = 0;
        dpk_c  = 0;
        dbt_c  = 0;
    endtask

    // Downstream ready: random per cycle with probability rdy_pct percent.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Monitor: every accepted master beat must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", {m_tlast, m_tkeep, m_tdata}, 128'h0);
                else chk("m_beat", 128'({m_tlast, m_tkeep, m_tdata}), 128'(exp_q.pop_front()));
            end
            if (s2_m_tvalid && m_tready) begin
                if (exp_q2.size() == 0) chk("unexpected_beat_s", {s2_m_tlast, s2_m_tkeep, s2_m_tdata}, 128'h0);
                else chk("m_beat_s", 128'({s2_m_tlast, s2_m_tkeep, s2_m_tdata}), 128'(exp_q2.pop_front()));
            end
        end
    end

    // Present one beat until accepted; first = packet's first beat, so an IDLE bubble precedes it.
    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                              input bit pass, input bit first, input bit clr);
        bit hs;
        bit bubble;
        logic exp_rdy;
        int cyc;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; stat_clear = clr;
        bubble = first; hs = 1'b0; cyc = 0;
        while (!hs) begin
            @(negedge clk);
            if (bubble) begin
                chk("idle_s_tready", 128'(s_tready), 128'(0));
                chk("idle_m_tvalid", 128'(m_tvalid), 128'(0));
                chk("idle_drop_active", 128'(drop_active), 128'(0));
                chk("idle_s_tready_s", 128'(s2_s_tready), 128'(0));
                bubble = 1'b0;
            end else begin
                exp_rdy = pass ? m_tready : 1'b1;
                chk("s_tready", 128'(s_tready), 128'(exp_rdy));
                chk("s_tready_s", 128'(s2_s_tready), 128'(exp_rdy));
                chk("m_tvalid", 128'(m_tvalid), 128'(pass));
                chk("drop_active", 128'(drop_active), 128'(!pass));
                chk("drop_active_s", 128'(s2_drop_active), 128'(!pass));
                chk("dbg_state", 128'(dbg_state), pass ? 128'(1) : 128'(2));
                hs = s_tready;
            end
            if (clr) zero_model();
            else if (hs) begin
                if (pass) begin
                    if (l) pass_c++;
                end else begin
                    dbt_c++;
                    if (l) dpk_c++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 500) begin
                chk("beat_timeout", 128'(1), 128'(0));
                break;
            end
        end
        stat_clear = 1'b0;
    endtask

    // toggle: 0 = hold dropn, 1 = invert after first beat, 2 = random after first beat.
    task automatic send_pkt(input int n, input bit pass, input int gap_pct, input int toggle,
                            input bit clr_last);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic l;
        dropn = pass;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            d = {$urandom, $urandom};
            k = KW'($urandom);
            l = (i == n - 1);
            if (pass) begin
                exp_q.push_back({l, k, d});
                exp_q2.push_back({l, k, d});
            end
            drive_beat(d, k, l, pass, i == 0, clr_last && l);
            if (i == 0 && toggle == 1) dropn = ~pass;
            if (i == 0 && toggle == 2) dropn = 1'($urandom_range(0, 1));
        end
        s_tvalid = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        @(negedge clk);
        chk({tag, "_pass"}, 128'(stat_pass), 128'(satv(pass_c, 32)));
        chk({tag, "_dpk"}, 128'(stat_dpk), 128'(satv(dpk_c, 32)));
        chk({tag, "_dbt"}, 128'(stat_dbt), 128'(satv(dbt_c, 32)));
        chk({tag, "_pass_s"}, 128'(s2_stat_pass), 128'(satv(pass_c, 4)));
        chk({tag, "_dpk_s"}, 128'(s2_stat_dpk), 128'(satv(dpk_c, 4)));
        chk({tag, "_dbt_s"}, 128'(s2_stat_dbt), 128'(satv(dbt_c, 4)));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        rst = 1'b1; dropn = 1'b1; stat_clear = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tkeep = '0;
        zero_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_drop_active", 128'(drop_active), 128'(0));
        chk("rst_dbg_state", 128'(dbg_state), 128'(0));
        @(posedge clk);
        #1;
        check_counters("rst");

        // Directed: pass 4 beats at full rate, then drop 3 beats with downstream stalled.
        rdy_pct = 100;
        send_pkt(4, 1'b1, 0, 0, 1'b0);
        check_counters("pass4");
        rdy_pct = 0;
        send_pkt(3, 1'b0, 0, 0, 1'b0);
        check_counters("drop3");

        // dropn flipped mid-packet must not affect the current packet.
        rdy_pct = 100;
        send_pkt(5, 1'b1, 0, 1, 1'b0);
        send_pkt(5, 1'b0, 0, 1, 1'b0);
        check_counters("toggle");

        // Random: 100 forwarded packets, then a mixed pass/drop run.
        rdy_pct = 50;
        for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 16), 1'b1, 30, 2, 1'b0);
        check_counters("rand_pass");
        for (int p = 0; p < 40; p++)
            send_pkt($urandom_range(1, 8), 1'($urandom_range(0, 1)), 30, 2, 1'b0);
        check_counters("rand_mix");

        // Saturation of the 4-bit counters, then clear colliding with a drop tlast.
        for (int p = 0; p < 20; p++) send_pkt(1, 1'b0, 0, 0, 1'b0);
        check_counters("sat");
        send_pkt(1, 1'b0, 0, 0, 1'b1);
        check_counters("clear");

        // Reset after two beats of a 4-beat pass packet; the rest restarts as a new packet.
        rdy_pct = 100;
        dropn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            k = KW'($urandom);
            exp_q.push_back({1'b0, k, d});
            exp_q2.push_back({1'b0, k, d});
            drive_beat(d, k, 1'b0, 1'b1, i == 0, 1'b0);
        end
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        zero_model();
        @(negedge clk);
        chk("midrst_s_tready", 128'(s_tready), 128'(0));
        chk("midrst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("midrst_drop_active", 128'(drop_active), 128'(0));
        @(posedge clk);
        #1;
        check_counters("midrst");
        for (int i = 2; i < 4; i++) begin
            d = {$urandom, $urandom};
            k = KW'($urandom);
            exp_q.push_back({i == 3, k, d});
            exp_q2.push_back({i == 3, k, d});
            drive_beat(d, k, i == 3, 1'b1, i == 2, 1'b0);
        end
        s_tvalid = 1'b0;
        check_counters("after_rst");

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
        chk("exp_q2_empty", 128'(exp_q2.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_s_packet_dropper.md
# axi_s_packet_dropper

Packet-granular AXI-stream dropper, parametrised in data width. It sits inline on a packet stream. The drop/pass decision is taken once per packet from `dropn`, at the packet's first beat, so packets are never truncated or spliced. Dropped packets are drained from the slave side at full rate, and pass/drop statistics counters are maintained.

## Interface
Parameters:
- `DATA_WIDTH`, 64, tdata width in bits; multiple of 8, ≥8
- `KEEP_WIDTH`, DATA_WIDTH/8, tkeep width
- `CNT_WIDTH`, 32, width of each statistics counter

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `dropn`  in  1  per-packet decision: 1 = pass, 0 = drop; sampled only at packet start
- `stat_clear`  in  1  synchronous clear of all three counters
- `s_packet_axis_tdata/tvalid/tlast/tkeep`  in  DATA_WIDTH/1/1/KEEP_WIDTH  slave stream
- `s_packet_axis_tready`  out  1  slave ready
- `m_packet_axis_tdata/tvalid/tlast/tkeep`  out  DATA_WIDTH/1/1/KEEP_WIDTH  master stream
- `m_packet_axis_tready`  in  1  master ready
- `drop_active`  out  1  high while the current packet is being dropped
- `stat_pass_pkts`  out  CNT_WIDTH  packets forwarded
- `stat_drop_pkts`  out  CNT_WIDTH  packets dropped
- `stat_drop_beats`  out  CNT_WIDTH  beats discarded

## Operation
- FSM states: IDLE, PASS, DROP.
- IDLE:
  - `s_tready`=0, `m_tvalid`=0.
  - If `s_tvalid`=1, latch `dropn`. Go to PASS if `dropn`=1, else to DROP. No beat moves in this cycle.
- PASS:
  - `m_tdata/tlast/tkeep` are driven combinationally from the slave side.
  - `m_tvalid`=`s_tvalid`, `s_tready`=`m_tready`.
  - A beat transfers when `s_tvalid`&`m_tready`. On a transfer with `tlast`=1: `stat_pass_pkts`+1, go to IDLE.
- DROP:
  - `s_tready`=1, `m_tvalid`=0. Master data outputs still follow the slave side but are ignored.
  - Every `s_tvalid` beat is consumed and increments `stat_drop_beats`.
  - On a beat with `tlast`=1: `stat_drop_pkts`+1, go to IDLE.
- `drop_active` = (state==DROP).
- `dropn` changes while in PASS or DROP have no effect until the next IDLE.
- Counters:
  - Unsigned and saturating at 2^CNT_WIDTH−1; they never wrap.
  - `stat_clear` and an increment in the same cycle → counter = 0 (clear wins).
- A single-beat packet (`tlast` on the first beat) is valid: IDLE → PASS/DROP → IDLE.
- `tkeep` is not inspected or modified.

## Timing
- Reset values:
  - state IDLE.
  - `s_tready`=0, `m_tvalid`=0, `drop_active`=0.
  - All counters 0.
- Data path latency in PASS is 0 cycles (combinational). No storage.
- Per-packet overhead: exactly 1 bubble cycle (IDLE) before the first beat.
  - Throughput is N/(N+1) for back-to-back N-beat packets.
- Counters update on the clock edge that completes the qualifying beat and are visible the next cycle.
- AXI rules:
  - Once `m_tvalid` rises in PASS, it cannot fall without `m_tready` or upstream `s_tvalid` falling, because the decision is latched.
  - Master payload is stable whenever the upstream holds it stable.
- Reset mid-packet returns to IDLE. Remaining beats of that packet are treated as a new packet and decided by the current `dropn`; upstream must reset in step.
- Back-pressure in DROP is impossible: `s_tready` is held at 1 regardless of `m_tready`.

## Test plan
- `dropn`=1, 4-beat packet, `m_tready`=1 → 1 IDLE cycle, then 4 beats out identical to input, last with `tlast`; `stat_pass_pkts`=1, others 0.
- `dropn`=0, 3-beat packet, `m_tready`=0 → `s_tready`=1 for all 3 beats, `m_tvalid` never 1; `stat_drop_pkts`=1, `stat_drop_beats`=3.
- `dropn`=1 at packet start, toggled to 0 mid-packet → whole 5-beat packet forwarded. The next packet, started with `dropn`=0, is fully dropped.
- PASS with random `m_tready` (~50%) and random `s_tvalid` gaps, 100 packets of 1–16 beats → output beat sequence matches input exactly; `stat_pass_pkts`=100.
- `CNT_WIDTH`=4, 20 dropped single-beat packets → `stat_drop_pkts` saturates at 15. Then `stat_clear` asserted concurrently with a drop `tlast` → counter 0 next cycle.
- `rst` pulsed on beat 2 of a 4-beat PASS packet → outputs return to reset values next cycle. Beat 3 restarts with an IDLE bubble.
